multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the bubble-sort MIPS-subset processor. Consumes the `opcode`/`funct` fields produced by the instruction decoder, the ALU zero flag and a memory ready handshake. Sequences fetch, decode, execute, memory and writeback by driving every datapath enable and mux select. Counts retired instructions and stops on halt or illegal encodings.

---
 rtl/proc_pkg.sv | 81 ++++++++
 rtl/alu_op_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset processor: opcodes, functs,
// ALU operations, control FSM states, PC source selects and the control bundle.
package proc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_I  = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_WB_R    = 4'd7,
        ST_WB_I    = 4'd8,
        ST_WB_MEM  = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_HALT    = 4'd12,
        ST_ILLEGAL = 4'd13
    } ctrl_state_e;

    // Every datapath enable and select driven by the control FSM.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       wb_src;
        logic       alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic ctrl_state_e decode_next(input logic [5:0] op);
        ctrl_state_e nxt;
        case (op)
            OP_RTYPE:        nxt = ST_EXEC_R;
            OP_ADDI, OP_SLTI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:    nxt = ST_ADDR;
            OP_BEQ, OP_BNE:  nxt = ST_BRANCH;
            OP_J:            nxt = ST_JUMP;
            OP_HALT:         nxt = ST_HALT;
            default:         nxt = ST_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation map with a legality flag; purely combinational.
// Unsupported functs report legal = 0 and fall back to ADD.
module alu_op_decode
    import proc_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing and retire count.
// 3-5 cycles per instruction; FETCH/MEM_RD/MEM_WR hold mem_req stable until mem_ready.
module multicycle_ctrl
    import proc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        wb_src,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic [31:0] retired,
    output logic        halted,
    output logic        illegal
);

    ctrl_state_e state;
    ctrl_state_e state_nxt;
    ctrl_t       ctrl;
    logic        retire;
    logic        br_taken;
    alu_op_e     fn_alu_op;
    logic        fn_legal;

    alu_op_decode u_alu_op_decode (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .legal  (fn_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        retire    = 1'b0;
        br_taken  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_SEQ;
                    state_nxt     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = decode_next(opcode);
            end
            ST_EXEC_R: begin
                ctrl.alu_op = fn_alu_op;
                state_nxt   = fn_legal ? ST_WB_R : ST_ILLEGAL;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_nxt      = ST_WB_I;
            end
            ST_ADDR: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                state_nxt      = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_src = 1'b1;
                if (mem_ready) begin
                    state_nxt = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.addr_src = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_WB_I: begin
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_src    = 1'b1;
                retire         = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_op   = ALU_SUB;
                ctrl.pc_write = br_taken;
                ctrl.pc_src   = PC_SRC_BRANCH;
                retire        = 1'b1;
                state_nxt     = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                retire        = 1'b1;
                state_nxt     = ST_FETCH;
            end
            ST_HALT, ST_ILLEGAL: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = ST_ILLEGAL;
            end
        endcase
    end

    // Architectural writes are suppressed on a reset edge so an IR/PC/regfile
    // load cannot slip through when reset lands on a completing access.
    assign mem_req   = ctrl.mem_req;
    assign mem_we    = ctrl.mem_we;
    assign addr_src  = ctrl.addr_src;
    assign ir_write  = ctrl.ir_write  & rst_n;
    assign pc_write  = ctrl.pc_write  & rst_n;
    assign pc_src    = ctrl.pc_src;
    assign reg_write = ctrl.reg_write & rst_n;
    assign reg_dst   = ctrl.reg_dst;
    assign wb_src    = ctrl.wb_src;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign halted    = (state == ST_HALT);
    assign illegal   = (state == ST_ILLEGAL);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench: each instruction expands into its expected per-cycle outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_src, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write, reg_dst, wb_src, alu_src_b;
    logic [3:0]  alu_op;
    logic [31:0] retired;
    logic        halted, illegal;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       wb_src;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic       halted;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t        o;
        logic [31:0] ret;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_no = 0;
    int          instr_cycles = 0;
    logic [31:0] m_ret = '0;
    logic [5:0]  i_op = '0;
    logic [5:0]  i_fn = '0;
    logic        i_z = 1'b0;
    obs_t        act;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_src  (addr_src),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .retired   (retired),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign act = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, wb_src, alu_src_b, alu_op, halted, illegal};

    // Compare process: one expected record per driven cycle.
    initial begin : cmp
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL ctrl cyc %0d: got %h expected %h", e.cyc, act, e.o);
                end
                checks++;
                if (retired !== e.ret) begin
                    errors++;
                    $display("FAIL retired cyc %0d: got %0d expected %0d", e.cyc, retired, e.ret);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic fn_ok(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h00;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'd0;
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            6'h00:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic obs_t f_fetch(input logic rdy, input logic rn);
        obs_t o;
        o          = '0;
        o.mem_req  = 1'b1;
        o.ir_write = rdy & rn;
        o.pc_write = rdy & rn;
        return o;
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cyc(input obs_t o, input logic mr, input logic rn);
        exp_t e;
        @(negedge clk);
        rst_n     = rn;
        mem_ready = mr;
        opcode    = i_op;
        funct     = i_fn;
        alu_zero  = i_z;
        e.o   = o;
        e.ret = m_ret;
        e.cyc = cycle_no;
        exp_q.push_back(e);
        cycle_no++;
        instr_cycles++;
    endtask

    // kind: 0 retired normally, 1 halted, 2 illegal
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input bit rst_fetch, output int kind);
        obs_t o;
        i_op = op;
        i_fn = fn;
        i_z  = z;
        instr_cycles = 0;
        kind = 0;
        repeat (wf) cyc(f_fetch(1'b0, 1'b1), 1'b0, 1'b1);
        if (rst_fetch) begin
            cyc(f_fetch(1'b1, 1'b0), 1'b1, 1'b0);
            m_ret = '0;
            instr_cycles = 0;
        end
        cyc(f_fetch(1'b1, 1'b1), 1'b1, 1'b1);
        cyc('0, rmr(), 1'b1);
        o = '0;
        case (op)
            6'h00: begin
                o.alu_op = alu_of(fn);
                cyc(o, rmr(), 1'b1);
                if (fn_ok(fn)) begin
                    o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
                    cyc(o, rmr(), 1'b1);
                end else begin
                    kind = 2;
                end
            end
            6'h08, 6'h0A: begin
                o.alu_src_b = 1'b1;
                o.alu_op = (op == 6'h0A) ? 4'd4 : 4'd0;
                cyc(o, rmr(), 1'b1);
                o = '0; o.reg_write = 1'b1;
                cyc(o, rmr(), 1'b1);
            end
            6'h23, 6'h2B: begin
                o.alu_src_b = 1'b1;
                cyc(o, rmr(), 1'b1);
                o = '0; o.mem_req = 1'b1; o.addr_src = 1'b1; o.mem_we = (op == 6'h2B);
                repeat (wm) cyc(o, 1'b0, 1'b1);
                cyc(o, 1'b1, 1'b1);
                if (op == 6'h23) begin
                    o = '0; o.reg_write = 1'b1; o.wb_src = 1'b1;
                    cyc(o, rmr(), 1'b1);
                end
            end
            6'h04, 6'h05: begin
                o.alu_op   = 4'd1;
                o.pc_src   = 2'd1;
                o.pc_write = (op == 6'h04) ? z : !z;
                cyc(o, rmr(), 1'b1);
            end
            6'h02: begin
                o.pc_write = 1'b1;
                o.pc_src   = 2'd2;
                cyc(o, rmr(), 1'b1);
            end
            6'h3F:   kind = 1;
            default: kind = 2;
        endcase
        if (kind == 0) m_ret = m_ret + 32'd1;
    endtask

    task automatic absorb(input int kind, input int n);
        obs_t o;
        o = '0;
        o.halted  = (kind == 1);
        o.illegal = (kind == 2);
        repeat (n) cyc(o, rmr(), 1'b1);
    endtask

    task automatic reset_from(input int kind);
        obs_t o;
        o = '0;
        o.halted  = (kind == 1);
        o.illegal = (kind == 2);
        cyc(o, rmr(), 1'b0);
        m_ret = '0;
    endtask

    logic [5:0] op_tab [12] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                                 6'h0A, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00};
    logic [5:0] fn_tab [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    initial begin : drive
        int k;
        int idx;
        logic [5:0] op, fn;
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0;
        // Reset-state check: FETCH with reset still held and memory ready.
        cyc(f_fetch(1'b1, 1'b0), 1'b1, 1'b0);

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, k);
        #3 lit("add wb reg_write/reg_dst", {30'd0, reg_write, reg_dst}, 32'd3);
        lit("add cycles", instr_cycles, 4);
        lit("add retired model", m_ret, 1);

        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0, k);
        #3 lit("lw wb_src", {31'd0, wb_src}, 32'd1);
        lit("lw wait cycles", instr_cycles, 7);

        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0, k);
        #3 lit("beq taken pc_write", {30'd0, pc_write, pc_src[0]}, 32'd3);
        lit("beq cycles", instr_cycles, 3);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0, k);
        #3 lit("bne not taken pc_write", {31'd0, pc_write}, 32'd0);
        lit("retired after branches", m_ret, 4);

        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b0, k);
        lit("sw cycles", instr_cycles, 4);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, k);
        lit("j cycles", instr_cycles, 3);
        #3 lit("retired dut before jump retire", retired, 32'd5);

        run_instr(6'h00, 6'h25, 1'b0, 2, 0, 1'b1, k);
        lit("retired after reset in fetch", m_ret, 1);

        run_instr(6'h3F, 6'h00, 1'b0, 1, 0, 1'b0, k);
        lit("halt kind", k, 1);
        absorb(k, 20);
        #3 lit("halted held", {31'd0, halted}, 32'd1);
        lit("retired frozen in halt", retired, 32'd1);
        reset_from(k);

        run_instr(6'h00, 6'h3B, 1'b0, 0, 0, 1'b0, k);
        lit("illegal funct kind", k, 2);
        absorb(k, 5);
        #3 lit("illegal held", {31'd0, illegal}, 32'd1);
        reset_from(k);

        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 11);
            op  = (idx == 11) ? 6'($urandom_range(0, 63)) : op_tab[idx];
            fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 5)];
            run_instr(op, fn, rmr(),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 15) == 0), k);
            if (k != 0) begin
                absorb(k, $urandom_range(1, 6));
                reset_from(k);
            end
        end

        repeat (3) @(negedge clk);
        #3 lit("expected queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
